// File: rtl/pwm_timer_core.sv
// PWM / timer core: control, divisor, period and duty registers with prescaler, counter and IRQ.
// Optional external count source enabled by defining PWM_TIMER_EXT_CLK_EN.
module pwm_timer_core #(
    parameter logic [15:0] base_adr        = 16'h0000,
    parameter logic [15:0] ctrl_spacing    = 16'd0,
    parameter logic [15:0] divisor_spacing = 16'd2,
    parameter logic [15:0] period_spacing  = 16'd4,
    parameter logic [15:0] DC_spacing      = 16'd6
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
`ifdef PWM_TIMER_EXT_CLK_EN
    input  logic        i_ext_clk,
`endif
    input  logic [15:0] i_reg_adr,
    input  logic [15:0] i_reg_data,
    input  logic        i_reg_we,
    output logic [15:0] o_reg_rdata,
    output logic        o_pwm,
    output logic        o_irq
);

    localparam logic [15:0] CtrlAdr    = base_adr + ctrl_spacing;
    localparam logic [15:0] DivisorAdr = base_adr + divisor_spacing;
    localparam logic [15:0] PeriodAdr  = base_adr + period_spacing;
    localparam logic [15:0] DcAdr      = base_adr + DC_spacing;

    logic        en_q, en_d;
    logic        mode_q, oe_q, ie_q, cont_q;
    logic        if_q, if_d;
    logic        extsel_q;
    logic [15:0] divisor_q;
    logic [15:0] period_sh_q, dc_sh_q;
    logic [15:0] period_act_q, dc_act_q;
    logic [15:0] presc_q, presc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pwm_q, pwm_d;
    logic        irq_q, irq_d;

    logic        wr_ctrl, wr_divisor, wr_period, wr_dc;
    logic        crst, inc, presc_wrap, cnt_wrap, period_live, tick, boundary, load_act;
    logic [15:0] div_eff;

    assign wr_ctrl    = i_reg_we && (i_reg_adr == CtrlAdr);
    assign wr_divisor = i_reg_we && (i_reg_adr == DivisorAdr);
    assign wr_period  = i_reg_we && (i_reg_adr == PeriodAdr);
    assign wr_dc      = i_reg_we && (i_reg_adr == DcAdr);
    assign crst       = wr_ctrl && i_reg_data[6];

`ifdef PWM_TIMER_EXT_CLK_EN
    logic [2:0] ext_sync_q;
    logic       ext_edge;
    logic       unused_data;

    // Two synchronizer flops plus one history flop for rising-edge detection.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            ext_sync_q <= 3'b000;
            extsel_q   <= 1'b0;
        end else begin
            ext_sync_q <= {ext_sync_q[1:0], i_ext_clk};
            if (wr_ctrl) begin
                extsel_q <= i_reg_data[7];
            end
        end
    end

    assign ext_edge    = ext_sync_q[1] && !ext_sync_q[2];
    assign inc         = extsel_q ? ext_edge : 1'b1;
    assign unused_data = ^i_reg_data[15:8];
`else
    logic unused_data;

    assign extsel_q    = 1'b0;
    assign inc         = 1'b1;
    assign unused_data = ^i_reg_data[15:7];
`endif

    assign div_eff     = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
    assign presc_wrap  = presc_q >= (div_eff - 16'd1);
    assign tick        = en_q && inc && presc_wrap;
    assign period_live = period_act_q != 16'd0;
    assign cnt_wrap    = cnt_q == (period_act_q - 16'd1);
    assign boundary    = tick && period_live && cnt_wrap && !crst;
    assign load_act    = boundary || !en_q || crst;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (!en_q || crst) begin
            presc_d = 16'd0;
            cnt_d   = 16'd0;
        end else if (inc) begin
            presc_d = presc_wrap ? 16'd0 : presc_q + 16'd1;
            if (presc_wrap && period_live) begin
                cnt_d = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        en_d = en_q;
        if (boundary && !mode_q && !cont_q) begin
            en_d = 1'b0;
        end
        // A bus write to EN overrides the one-shot auto-clear.
        if (wr_ctrl) begin
            en_d = i_reg_data[0];
        end
        if_d = if_q;
        if (wr_ctrl && i_reg_data[5]) begin
            if_d = 1'b0;
        end
        if (boundary) begin
            if_d = 1'b1;
        end
        pwm_d = mode_q && en_q && oe_q && period_live && (cnt_q < dc_act_q);
        irq_d = if_q && ie_q;
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            en_q         <= 1'b0;
            mode_q       <= 1'b0;
            oe_q         <= 1'b0;
            ie_q         <= 1'b0;
            cont_q       <= 1'b0;
            if_q         <= 1'b0;
            divisor_q    <= 16'd0;
            period_sh_q  <= 16'd0;
            dc_sh_q      <= 16'd0;
            period_act_q <= 16'd0;
            dc_act_q     <= 16'd0;
            presc_q      <= 16'd0;
            cnt_q        <= 16'd0;
            pwm_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            en_q    <= en_d;
            if_q    <= if_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            irq_q   <= irq_d;
            if (wr_ctrl) begin
                mode_q <= i_reg_data[1];
                oe_q   <= i_reg_data[2];
                ie_q   <= i_reg_data[3];
                cont_q <= i_reg_data[4];
            end
            if (wr_divisor) begin
                divisor_q <= i_reg_data;
            end
            if (wr_period) begin
                period_sh_q <= i_reg_data;
            end
            if (wr_dc) begin
                dc_sh_q <= i_reg_data;
            end
            if (load_act) begin
                period_act_q <= period_sh_q;
                dc_act_q     <= dc_sh_q;
            end
        end
    end

    always_comb begin
        o_reg_rdata = 16'd0;
        if (i_reg_adr == CtrlAdr) begin
            o_reg_rdata = {8'd0, extsel_q, 1'b0, if_q, cont_q, ie_q, oe_q, mode_q, en_q};
        end else if (i_reg_adr == DivisorAdr) begin
            o_reg_rdata = divisor_q;
        end else if (i_reg_adr == PeriodAdr) begin
            o_reg_rdata = period_sh_q;
        end else if (i_reg_adr == DcAdr) begin
            o_reg_rdata = dc_sh_q;
        end
    end

    assign o_pwm = pwm_q;
    assign o_irq = irq_q;

endmodule

// File: tb/tb_pwm_timer_core.sv
// Directed self-checking bench for pwm_timer_core (default build, no external clock).
module tb_pwm_timer_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [15:0] adr, data, rdata;
    logic        pwm, irq;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pwm_timer_core dut (
        .i_wb_clk   (clk),
        .i_wb_rst   (rst),
        .i_reg_adr  (adr),
        .i_reg_data (data),
        .i_reg_we   (we),
        .o_reg_rdata(rdata),
        .o_pwm      (pwm),
        .o_irq      (irq)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        adr  = a;
        data = d;
        we   = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        adr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        adr  = 16'd0;
        data = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(16'h0000, 16'h0000, "init_ctrl");
        check("init_pwm", {15'd0, pwm}, 16'd0);
        check("init_irq", {15'd0, irq}, 16'd0);

        // Reset clears previously written registers
        wr(16'h0002, 16'd5);
        wr(16'h0004, 16'd7);
        wr(16'h0006, 16'd3);
        wr(16'h0000, 16'h0016);
        rd(16'h0004, 16'd7, "pre_rst_period");
        rd(16'h0000, 16'h0016, "pre_rst_ctrl");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(16'h0000, 16'd0, "rst_ctrl");
        rd(16'h0002, 16'd0, "rst_divisor");
        rd(16'h0004, 16'd0, "rst_period");
        rd(16'h0006, 16'd0, "rst_dc");
        check("rst_pwm", {15'd0, pwm}, 16'd0);
        check("rst_irq", {15'd0, irq}, 16'd0);

        // PWM: divisor 2, period 4, duty 1 -> 2 high / 6 low
        wr(16'h0002, 16'd2);
        wr(16'h0004, 16'd4);
        wr(16'h0006, 16'd1);
        wr(16'h0000, 16'h0007);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("pwm_wave", {15'd0, pwm}, (((i / 2) % 4) < 1) ? 16'd1 : 16'd0);
            check("pwm_irq", {15'd0, irq}, 16'd0);
            if (i == 6) rd(16'h0000, 16'h0007, "pwm_if_clear");
            if (i == 7) rd(16'h0000, 16'h0027, "pwm_if_set");
        end

        // Shadow DC update mid-period; CRST + IF clear realigns the count
        wr(16'h0000, 16'h0067);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("shadow_wave", {15'd0, pwm},
                  (((i / 2) % 4) < ((i >= 8) ? 3 : 1)) ? 16'd1 : 16'd0);
            if (i == 3) begin
                adr  = 16'h0006;
                data = 16'd3;
                we   = 1'b1;
            end
            if (i == 4) begin
                we = 1'b0;
                rd(16'h0006, 16'd3, "shadow_dc_read");
            end
        end

        // Duty boundaries
        wr(16'h0006, 16'd0);
        wr(16'h0000, 16'h0067);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("dc0_low", {15'd0, pwm}, 16'd0);
        end
        wr(16'h0006, 16'd5);
        wr(16'h0000, 16'h0067);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("dc_over_high", {15'd0, pwm}, 16'd1);
        end

        // One-shot timer with interrupt
        wr(16'h0000, 16'h0020);
        wr(16'h0002, 16'd1);
        wr(16'h0004, 16'd3);
        wr(16'h0000, 16'h0009);
        @(negedge clk);
        @(negedge clk);
        rd(16'h0000, 16'h0009, "oneshot_run");
        @(negedge clk);
        rd(16'h0000, 16'h0028, "oneshot_done");
        check("oneshot_irq_lag", {15'd0, irq}, 16'd0);
        @(negedge clk);
        check("oneshot_irq", {15'd0, irq}, 16'd1);
        check("oneshot_pwm", {15'd0, pwm}, 16'd0);
        wr(16'h0000, 16'h0028);
        check("w1c_irq_lag", {15'd0, irq}, 16'd1);
        @(negedge clk);
        check("w1c_irq", {15'd0, irq}, 16'd0);
        rd(16'h0000, 16'h0008, "w1c_ctrl");

        // Unmapped write
        wr(16'h0008, 16'hFFFF);
        rd(16'h0008, 16'h0000, "unmapped_read");
        rd(16'h0000, 16'h0008, "unmapped_ctrl");
        rd(16'h0002, 16'd1, "unmapped_div");
        rd(16'h0004, 16'd3, "unmapped_period");
        rd(16'h0006, 16'd5, "unmapped_dc");

        // CRST mid-count: divisor 1, period 10, duty 2
        wr(16'h0004, 16'd10);
        wr(16'h0006, 16'd2);
        wr(16'h0000, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("crst_pre", {15'd0, pwm}, ((i % 10) < 2) ? 16'd1 : 16'd0);
        end
        adr  = 16'h0000;
        data = 16'h0047;
        we   = 1'b1;
        @(negedge clk);
        we = 1'b0;
        check("crst_e6", {15'd0, pwm}, 16'd0);
        rd(16'h0000, 16'h0007, "crst_ctrl_read");
        @(negedge clk);
        check("crst_e7", {15'd0, pwm}, 16'd1);
        @(negedge clk);
        check("crst_e8", {15'd0, pwm}, 16'd1);
        @(negedge clk);
        check("crst_e9", {15'd0, pwm}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
